// File: rtl/monopix_bridge_pkg.sv
// Shared types and helpers for the MONOPIX arbiter-to-readout-FIFO bridge.
package monopix_bridge_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, HOLD, DRAIN} state_t;

  // Word identifiers carried in the top nibble of each arbiter word
  localparam logic [3:0] ID_TS  = 4'h4;
  localparam logic [3:0] ID_INJ = 4'h5;
  localparam logic [3:0] ID_MON = 4'h6;
  localparam logic [3:0] ID_TLU = 4'h7;
  localparam int         ID_MSB = 31;
  localparam int         ID_LSB = 28;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bridge_sfifo.sv
// Synchronous first-word-fall-through buffer. The head is read straight
// from the array at the read pointer; a push into an empty buffer becomes
// visible on the next cycle (no bypass path).
module bridge_sfifo #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_fill
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_fill;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_fill == '0);
  assign o_full  = (r_fill == FULL_LVL);
  assign o_fill  = r_fill;
  assign o_head  = r_mem[r_rd];
  // A push into a full buffer is dropped rather than corrupting the head
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array, no reset: contents are qualified by r_fill
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_din;

  // Pointers wrap modulo DEPTH; occupancy tracked separately in AW+1 bits
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && o_full));

endmodule

// File: rtl/monopix_arb_fifo_bridge.sv
// Elastic stage between the MONOPIX arbiter and the SiTCP/USB readout FIFO.
// Optional per-identifier word counters are built when
// MONOPIX_BRIDGE_STATS_EN is defined.
module monopix_arb_fifo_bridge
  import monopix_bridge_pkg::*;
#(
  parameter  int DEPTH        = 64,
  parameter  int READY_MARGIN = 2,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        ENABLE,
  input  logic        CNT_CLR,
  input  logic        ARB_WRITE_IN,
  input  logic [31:0] ARB_DATA_IN,
  output logic        ARB_READY_OUT,
  input  logic        FIFO_FULL,
  input  logic        FIFO_NEAR_FULL,
  output logic        FIFO_WRITE,
  output logic [31:0] FIFO_DATA,
  output logic [AW:0] FILL,
  output logic [AW:0] MAX_FILL,
  output logic [31:0] WORD_CNT,
  output logic [15:0] STALL_CNT,
`ifdef MONOPIX_BRIDGE_STATS_EN
  output logic [15:0] ID_CNT_TS,
  output logic [15:0] ID_CNT_INJ,
  output logic [15:0] ID_CNT_MON,
  output logic [15:0] ID_CNT_TLU,
  output logic [15:0] ID_CNT_OTHER,
`endif
  output logic        DRAINED
);

  // Ready drops early enough that the word already in flight still fits
  localparam logic [AW:0] READY_LIM = (AW+1)'(DEPTH - READY_MARGIN - 1);

  state_t      r_state;
  logic        r_ready;
  logic        r_drained;
  logic [AW:0] r_max_fill;
  logic [31:0] r_word_cnt;
  logic [15:0] r_stall_cnt;

  logic [31:0] w_head;
  logic        w_empty;
  logic        w_full;
  logic [AW:0] w_fill;
  logic [AW:0] w_fill_nx;
  logic        w_empty_nx;
  logic        w_push;
  logic        w_pop;

  assign w_push     = ARB_WRITE_IN && r_ready;
  assign w_pop      = (r_state == STREAM || r_state == DRAIN) && !w_empty && !FIFO_FULL;
  assign w_empty_nx = (w_fill_nx == '0);

  assign ARB_READY_OUT = r_ready;
  assign FIFO_WRITE    = w_pop;
  assign FIFO_DATA     = w_empty ? 32'd0 : w_head;
  assign FILL          = w_fill;
  assign MAX_FILL      = r_max_fill;
  assign WORD_CNT      = r_word_cnt;
  assign STALL_CNT     = r_stall_cnt;
  assign DRAINED       = r_drained;

  bridge_sfifo #(.DEPTH(DEPTH), .WIDTH(32)) u_buf (
    .i_clk   (BUS_CLK),
    .i_rst_n (BUS_RST_N),
    .i_push  (w_push),
    .i_din   (ARB_DATA_IN),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_fill  (w_fill)
  );

  // Occupancy after this cycle's push/pop, used for ready and state decisions
  always_comb begin
    w_fill_nx = w_fill;
    if (w_push && !w_pop)      w_fill_nx = w_fill + 1'b1;
    else if (w_pop && !w_push) w_fill_nx = w_fill - 1'b1;
  end

  // Flow-control FSM with registered ready and drained flags.
  // Decisions look at next-cycle occupancy so a freshly accepted word is
  // streamed on the very next cycle.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N)
    if (!BUS_RST_N) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_drained <= 1'b1;
    end else begin
      r_ready   <= ENABLE && (w_fill_nx <= READY_LIM);
      r_drained <= !ENABLE && w_empty_nx;
      case (r_state)
        IDLE:
          if (!ENABLE)          r_state <= DRAIN;
          else if (!w_empty_nx) r_state <= FIFO_NEAR_FULL ? HOLD : STREAM;
        STREAM:
          if (FIFO_NEAR_FULL)   r_state <= HOLD;
          else if (!ENABLE)     r_state <= DRAIN;
          else if (w_empty_nx)  r_state <= IDLE;
        HOLD:
          if (!FIFO_NEAR_FULL) begin
            if (!ENABLE)         r_state <= DRAIN;
            else if (w_empty_nx) r_state <= IDLE;
            else                 r_state <= STREAM;
          end
        DRAIN:
          if (FIFO_NEAR_FULL)            r_state <= HOLD;
          else if (ENABLE && w_empty_nx) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end

  // Run-monitoring counters; a clear overrides any same-cycle increment
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N)
    if (!BUS_RST_N) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
      r_max_fill  <= '0;
    end else if (CNT_CLR) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
      r_max_fill  <= '0;
    end else begin
      if (w_push)                      r_word_cnt  <= sat_inc32(r_word_cnt);
      if (r_state == HOLD && !w_empty) r_stall_cnt <= sat_inc16(r_stall_cnt);
      if (w_fill > r_max_fill)         r_max_fill  <= w_fill;
    end

  a_no_write_at_full: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_N)
    !(w_push && w_full));

`ifdef MONOPIX_BRIDGE_STATS_EN
  logic [15:0] r_id_ts;
  logic [15:0] r_id_inj;
  logic [15:0] r_id_mon;
  logic [15:0] r_id_tlu;
  logic [15:0] r_id_other;
  logic [3:0]  w_id;

  assign w_id         = ARB_DATA_IN[ID_MSB:ID_LSB];
  assign ID_CNT_TS    = r_id_ts;
  assign ID_CNT_INJ   = r_id_inj;
  assign ID_CNT_MON   = r_id_mon;
  assign ID_CNT_TLU   = r_id_tlu;
  assign ID_CNT_OTHER = r_id_other;

  // Per-identifier tallies of accepted words
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N)
    if (!BUS_RST_N || CNT_CLR) begin
      r_id_ts    <= '0;
      r_id_inj   <= '0;
      r_id_mon   <= '0;
      r_id_tlu   <= '0;
      r_id_other <= '0;
    end else if (w_push) begin
      case (w_id)
        ID_TS:   r_id_ts    <= sat_inc16(r_id_ts);
        ID_INJ:  r_id_inj   <= sat_inc16(r_id_inj);
        ID_MON:  r_id_mon   <= sat_inc16(r_id_mon);
        ID_TLU:  r_id_tlu   <= sat_inc16(r_id_tlu);
        default: r_id_other <= sat_inc16(r_id_other);
      endcase
    end
`endif

endmodule

// File: tb/tb_monopix_arb_fifo_bridge.sv
// Directed scoreboard bench for monopix_arb_fifo_bridge (DEPTH=64).
module tb_monopix_arb_fifo_bridge;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N;
  logic        ENABLE;
  logic        CNT_CLR;
  logic        ARB_WRITE_IN;
  logic [31:0] ARB_DATA_IN;
  logic        ARB_READY_OUT;
  logic        FIFO_FULL;
  logic        FIFO_NEAR_FULL;
  logic        FIFO_WRITE;
  logic [31:0] FIFO_DATA;
  logic [6:0]  FILL;
  logic [6:0]  MAX_FILL;
  logic [31:0] WORD_CNT;
  logic [15:0] STALL_CNT;
  logic        DRAINED;
`ifdef MONOPIX_BRIDGE_STATS_EN
  logic [15:0] ID_CNT_TS, ID_CNT_INJ, ID_CNT_MON, ID_CNT_TLU, ID_CNT_OTHER;
`endif

  monopix_arb_fifo_bridge #(.DEPTH(64), .READY_MARGIN(2)) dut (
    .BUS_CLK        (BUS_CLK),
    .BUS_RST_N      (BUS_RST_N),
    .ENABLE         (ENABLE),
    .CNT_CLR        (CNT_CLR),
    .ARB_WRITE_IN   (ARB_WRITE_IN),
    .ARB_DATA_IN    (ARB_DATA_IN),
    .ARB_READY_OUT  (ARB_READY_OUT),
    .FIFO_FULL      (FIFO_FULL),
    .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
    .FIFO_WRITE     (FIFO_WRITE),
    .FIFO_DATA      (FIFO_DATA),
    .FILL           (FILL),
    .MAX_FILL       (MAX_FILL),
    .WORD_CNT       (WORD_CNT),
    .STALL_CNT      (STALL_CNT),
`ifdef MONOPIX_BRIDGE_STATS_EN
    .ID_CNT_TS      (ID_CNT_TS),
    .ID_CNT_INJ     (ID_CNT_INJ),
    .ID_CNT_MON     (ID_CNT_MON),
    .ID_CNT_TLU     (ID_CNT_TLU),
    .ID_CNT_OTHER   (ID_CNT_OTHER),
`endif
    .DRAINED        (DRAINED)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] q[$];
  int          n_acc = 0;
  int          n_out = 0;
  int          first_acc = -1;
  int          first_wr = -1;
  bit          nf_chk = 0;
  bit          drain_chk = 0;
  int          peak = 0;

  always @(posedge BUS_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge BUS_CLK);
    #1;
  endtask

  // Scoreboard monitor: pop-and-compare before pushing so a bypass would show
  always @(negedge BUS_CLK) begin
    if (BUS_RST_N === 1'b1) begin
      if (drain_chk) chk("drained_flag", {31'd0, DRAINED}, {31'd0, q.size() == 0});
      if (FIFO_FULL) chk("write_while_full", {31'd0, FIFO_WRITE}, 32'd0);
      if (nf_chk) begin
        chk("write_in_hold", {31'd0, FIFO_WRITE}, 32'd0);
        if (int'(FILL) > peak) peak = int'(FILL);
      end
      if (FIFO_WRITE) begin
        if (first_wr < 0) first_wr = cyc;
        if (q.size() == 0) chk("spurious_write", {31'd0, FIFO_WRITE}, 32'd0);
        else chk("data_order", FIFO_DATA, q.pop_front());
        n_out++;
      end
      if (ARB_WRITE_IN && ARB_READY_OUT) begin
        if (first_acc < 0) first_acc = cyc;
        q.push_back(ARB_DATA_IN);
        n_acc++;
      end
    end
  end

  task automatic push_words(input int n, input logic [31:0] base, output int sent);
    int k = 0;
    logic acc;
    sent = 0;
    while (sent < n && k < 500) begin
      ARB_WRITE_IN = 1'b1;
      ARB_DATA_IN  = base + 32'(sent);
      acc = ARB_READY_OUT;
      step();
      if (acc) sent++;
      k++;
    end
    ARB_WRITE_IN = 1'b0;
    chk("push_budget", 32'(sent), 32'(n));
  endtask

  task automatic wait_out();
    int k = 0;
    while (q.size() != 0 && k < 2000) begin
      step();
      k++;
    end
    chk("drain_budget", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   {31'd0, ARB_READY_OUT}, 32'd0);
    chk({tag, "_fwrite"},  {31'd0, FIFO_WRITE}, 32'd0);
    chk({tag, "_fdata"},   FIFO_DATA, 32'd0);
    chk({tag, "_fill"},    {25'd0, FILL}, 32'd0);
    chk({tag, "_maxfill"}, {25'd0, MAX_FILL}, 32'd0);
    chk({tag, "_wcnt"},    WORD_CNT, 32'd0);
    chk({tag, "_scnt"},    {16'd0, STALL_CNT}, 32'd0);
    chk({tag, "_drained"}, {31'd0, DRAINED}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, k, out0;
    logic acc;
    BUS_RST_N = 1'b0; ENABLE = 1'b0; CNT_CLR = 1'b0;
    ARB_WRITE_IN = 1'b0; ARB_DATA_IN = '0;
    FIFO_FULL = 1'b0; FIFO_NEAR_FULL = 1'b0;
    #23;
    chk_reset_vals("rst");
    BUS_RST_N = 1'b1;
    ENABLE = 1'b1;
    step(); step();
    chk("ready_after_enable", {31'd0, ARB_READY_OUT}, 32'd1);
    chk("not_drained_enabled", {31'd0, DRAINED}, 32'd0);

    // Basic flow
    first_acc = -1; first_wr = -1; out0 = n_out;
    push_words(10, 32'h4000_0000, sent);
    wait_out();
    chk("first_latency", 32'(first_wr - first_acc), 32'd1);
    chk("basic_out", 32'(n_out - out0), 32'd10);
    chk("basic_wcnt", WORD_CNT, 32'd10);
    chk("basic_maxfill_le2", {31'd0, MAX_FILL <= 7'd2}, 32'd1);

    // Backpressure: near-full held for 100 cycles with continuous pushes
    CNT_CLR = 1'b1; step(); CNT_CLR = 1'b0;
    out0 = n_out; peak = 0; sent = 0;
    FIFO_NEAR_FULL = 1'b1; nf_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ARB_WRITE_IN = 1'b1;
      ARB_DATA_IN  = 32'h5000_0000 + 32'(sent);
      acc = ARB_READY_OUT;
      step();
      if (acc) sent++;
    end
    chk("bp_accepted", 32'(sent), 32'd62);
    chk("bp_fill", {25'd0, FILL}, 32'd62);
    chk("bp_ready_low", {31'd0, ARB_READY_OUT}, 32'd0);
    ARB_WRITE_IN = 1'b0; FIFO_NEAR_FULL = 1'b0;
    step();
    nf_chk = 1'b0;
    chk("bp_peak", 32'(peak), 32'd62);
    wait_out();
    chk("bp_out", 32'(n_out - out0), 32'd62);
    chk("bp_stall", {16'd0, STALL_CNT}, 32'd100);
    chk("bp_maxfill", {25'd0, MAX_FILL}, 32'd62);
    chk("bp_wcnt", WORD_CNT, 32'd62);

    // FIFO_FULL toggling every 3 cycles during streaming
    out0 = n_out; sent = 0; k = 0;
    while ((sent < 30 || q.size() != 0) && k < 1000) begin
      FIFO_FULL    = ((k / 3) % 2) == 1;
      ARB_WRITE_IN = (sent < 30);
      ARB_DATA_IN  = 32'h6000_0000 + 32'(sent);
      acc = ARB_READY_OUT && ARB_WRITE_IN;
      step();
      if (acc) sent++;
      k++;
    end
    FIFO_FULL = 1'b0; ARB_WRITE_IN = 1'b0;
    chk("full_sent", 32'(sent), 32'd30);
    chk("full_out", 32'(n_out - out0), 32'd30);
    chk("full_queue_empty", 32'(q.size()), 32'd0);

    // Drain: buffer 20 under near-full, then disable and release
    CNT_CLR = 1'b1; step(); CNT_CLR = 1'b0;
    out0 = n_out;
    FIFO_NEAR_FULL = 1'b1; nf_chk = 1'b1;
    push_words(20, 32'h7000_0000, sent);
    step();
    chk("drain_fill", {25'd0, FILL}, 32'd20);
    ENABLE = 1'b0; FIFO_NEAR_FULL = 1'b0; nf_chk = 1'b0;
    step();
    chk("drain_ready_low", {31'd0, ARB_READY_OUT}, 32'd0);
    ARB_WRITE_IN = 1'b1; ARB_DATA_IN = 32'hDEAD_BEEF;
    drain_chk = 1'b1;
    wait_out();
    step(); step();
    drain_chk = 1'b0;
    ARB_WRITE_IN = 1'b0;
    chk("drain_out", 32'(n_out - out0), 32'd20);
    chk("drain_drained", {31'd0, DRAINED}, 32'd1);
    chk("drain_ignored_writes", WORD_CNT, 32'd20);
    ENABLE = 1'b1;
    step(); step();
    chk("reenable_ready", {31'd0, ARB_READY_OUT}, 32'd1);
    chk("reenable_drained", {31'd0, DRAINED}, 32'd0);

    // Clear coinciding with an accept
    ARB_WRITE_IN = 1'b1; ARB_DATA_IN = 32'h4123_0000; CNT_CLR = 1'b1;
    step();
    ARB_WRITE_IN = 1'b0; CNT_CLR = 1'b0;
    chk("clr_wins", WORD_CNT, 32'd0);
    wait_out();
    push_words(1, 32'h4124_0000, sent);
    wait_out();
    chk("cnt_after_clr", WORD_CNT, 32'd1);

    // Asynchronous reset in the middle of a stream
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ARB_WRITE_IN = 1'b1; ARB_DATA_IN = 32'hBAD0_0000 + 32'(i);
      step();
    end
    BUS_RST_N = 1'b0;
    #2;
    chk_reset_vals("midrst");
    q.delete();
    ARB_WRITE_IN = 1'b0; FIFO_FULL = 1'b0;
    step();
    BUS_RST_N = 1'b1;
    step(); step();
    out0 = n_out;
    push_words(3, 32'h4300_0000, sent);
    wait_out();
    chk("post_rst_out", 32'(n_out - out0), 32'd3);
    chk("post_rst_wcnt", WORD_CNT, 32'd3);

`ifdef MONOPIX_BRIDGE_STATS_EN
    CNT_CLR = 1'b1; step(); CNT_CLR = 1'b0;
    push_words(3, 32'h6000_0100, sent);
    push_words(2, 32'h4000_0100, sent);
    push_words(1, 32'h0000_0100, sent);
    wait_out();
    step();
    chk("id_mon",   {16'd0, ID_CNT_MON},   32'd3);
    chk("id_ts",    {16'd0, ID_CNT_TS},    32'd2);
    chk("id_other", {16'd0, ID_CNT_OTHER}, 32'd1);
    chk("id_inj",   {16'd0, ID_CNT_INJ},   32'd0);
    chk("id_tlu",   {16'd0, ID_CNT_TLU},   32'd0);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/monopix_arb_fifo_bridge.md
Name: monopix_arb_fifo_bridge

Overview:
- Elastic stage directly downstream of the arbiter output of the MONOPIX core. Sits between the arbiter and the SiTCP/USB readout FIFO.
- Accepts 32-bit words with a WRITE/READY handshake into a local first-word-fall-through (FWFT) buffer.
- Drains the buffer into the readout FIFO, honouring FIFO_FULL and FIFO_NEAR_FULL.
- Provides enable/drain control, fill high-water mark and throughput/stall counters for run monitoring.

Parameters:
- DEPTH, 64, buffer depth in 32-bit words; power of 2, minimum 8.
- READY_MARGIN, 2, free entries reserved to absorb the registered-ready latency.
- AW, $clog2(DEPTH), buffer address width (derived).

Ports:
- BUS_CLK  in  1  single clock for the whole block.
- BUS_RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  level; 1 = accept words from the arbiter.
- CNT_CLR  in  1  synchronous one-cycle pulse; clears the counters and the high-water mark.
- ARB_WRITE_IN  in  1  word valid from the arbiter.
- ARB_DATA_IN  in  32  word from the arbiter.
- ARB_READY_OUT  out  1  ready to the arbiter (registered).
- FIFO_FULL  in  1  readout FIFO full.
- FIFO_NEAR_FULL  in  1  readout FIFO almost full.
- FIFO_WRITE  out  1  write strobe to the readout FIFO.
- FIFO_DATA  out  32  data to the readout FIFO.
- FILL  out  AW+1  current buffer occupancy.
- MAX_FILL  out  AW+1  high-water mark of FILL.
- WORD_CNT  out  32  words accepted, saturating.
- STALL_CNT  out  16  cycles spent in HOLD with a non-empty buffer, saturating.
- DRAINED  out  1  ENABLE=0 and buffer empty.

Behaviour:
- Reset (BUS_RST_N=0, asynchronous):
  - Outputs: ARB_READY_OUT=0, FIFO_WRITE=0, FIFO_DATA=0, FILL=0, MAX_FILL=0, WORD_CNT=0, STALL_CNT=0, DRAINED=1.
  - Internal: state=IDLE, pointers=0.
  - Reset mid-operation discards buffer contents.
- Accept rule:
  - A word is written when ARB_WRITE_IN && ARB_READY_OUT.
  - ARB_READY_OUT <= ENABLE && (FILL_next <= DEPTH-READY_MARGIN-1), registered each cycle.
  - ARB_WRITE_IN while ARB_READY_OUT=0 is ignored and not counted.
  - Overflow is impossible by construction; a write attempt at FILL==DEPTH is dropped and flagged by an assertion.
- Output rule (combinational from FWFT head):
  - FIFO_WRITE = (state==STREAM || state==DRAIN) && !empty && !FIFO_FULL.
  - FIFO_DATA = head word.
  - A pop occurs on FIFO_WRITE.
- Latency: a word accepted at cycle t can appear on FIFO_WRITE at cycle t+1 at the earliest.
- Simultaneous push and pop: FILL is unchanged; this is allowed at FILL==0 only after the push lands, i.e. there is no bypass path.
- State machine:
  - IDLE: buffer empty and ENABLE=1. Go to STREAM on !empty.
  - STREAM: go to HOLD on FIFO_NEAR_FULL. Go to DRAIN on !ENABLE. Go to IDLE on empty.
  - HOLD: no writes. Go to STREAM when !FIFO_NEAR_FULL. If ENABLE drops, stay in HOLD (near-full still has priority), then go to DRAIN.
  - DRAIN: ENABLE=0, keep popping. Go to IDLE when empty && ENABLE. Stay in DRAIN while empty && !ENABLE (DRAINED=1).
  - Priority per cycle: FIFO_NEAR_FULL > ENABLE change > empty.
- DRAINED = !ENABLE && empty.
- Counters:
  - WORD_CNT: +1 per accepted word, saturating at 0xFFFF_FFFF.
  - STALL_CNT: +1 per cycle in HOLD with !empty, saturating at 0xFFFF.
  - MAX_FILL: updated to FILL when FILL > MAX_FILL.
  - CNT_CLR clears all three. An increment in the same cycle as CNT_CLR is lost; the clear wins.
- Pointers wrap modulo DEPTH. FILL is kept in AW+1 bits so FILL==DEPTH is representable.

Optional Feature:
- Macro: MONOPIX_BRIDGE_STATS_EN.
- Defined:
  - Adds ID_CNT_TS, ID_CNT_INJ, ID_CNT_MON and ID_CNT_TLU outputs, 16 bits each, saturating.
  - Each counts accepted words whose ARB_DATA_IN[31:28] equals 4'b0100, 4'b0101, 4'b0110 and 4'b0111 respectively.
  - ID_CNT_OTHER (16 bits) counts all other accepted words.
  - All five are cleared by CNT_CLR and reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package monopix_bridge_pkg:
  - State enum {IDLE, STREAM, HOLD, DRAIN}.
  - Identifier constants ID_TS=4'h4, ID_INJ=4'h5, ID_MON=4'h6, ID_TLU=4'h7.
  - ID field position [31:28].
  - Saturating-increment function.
- Sub-module bridge_sfifo: synchronous FWFT buffer with parameters DEPTH and WIDTH, ports push/pop/head/empty/full/fill.
- The state machine, handshake and counters stay in the top level.

Test Plan:
- Basic flow: ENABLE=1, FIFO_FULL=0, 10 words 0x4000_0000..0x4000_0009 back-to-back → same 10 words on FIFO_DATA in order, first FIFO_WRITE one cycle after first accept, WORD_CNT=10, MAX_FILL<=2.
- Backpressure: FIFO_NEAR_FULL=1 for 100 cycles while the arbiter pushes continuously, DEPTH=64 → no FIFO_WRITE; ARB_READY_OUT falls once FILL reaches 62; FILL peaks at 62, never 64; STALL_CNT=100 (buffer non-empty); after release, all 62 words emerge in order.
- FIFO_FULL: toggle FIFO_FULL every 3 cycles during streaming → FIFO_WRITE=0 in every FIFO_FULL=1 cycle; no word lost or duplicated (scoreboard).
- Drain: 20 words buffered with FIFO_NEAR_FULL=1, then ENABLE=0 and near-full released → ARB_READY_OUT=0 from the next cycle; 20 words out; DRAINED=1 exactly on the cycle the buffer empties.
- Reset and clear:
  - BUS_RST_N pulsed low mid-stream → all outputs at reset values asynchronously; FILL=0.
  - Separately, CNT_CLR in the same cycle as an accept → WORD_CNT=0.
- With MONOPIX_BRIDGE_STATS_EN: push 3×ID 4'h6, 2×4'h4, 1×4'h0 → ID_CNT_MON=3, ID_CNT_TS=2, ID_CNT_OTHER=1.
